// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficient ROM and FSM encoding for the CIC droop-compensation FIR.
package cic_comp_pkg;

    localparam int CIC_COMP_TAPS = 15;

    // Symmetric inverse-sinc^2 shape for N=2, R=16; taps sum to 2^17 for unity DC gain.
    localparam logic signed [17:0] CIC_COMP_COEFS [CIC_COMP_TAPS] = '{
        -18'sd100,  -18'sd250,   18'sd300,   18'sd900,  -18'sd1200,
        -18'sd3000,  18'sd12000, 18'sd113772, 18'sd12000, -18'sd3000,
        -18'sd1200,  18'sd900,   18'sd300,  -18'sd250,  -18'sd100
    };

    typedef enum logic [1:0] {IDLE, MAC, DONE} cic_comp_state_e;

    function automatic logic [3:0] ptr_inc(input logic [3:0] p);
        return (p == 4'(CIC_COMP_TAPS - 1)) ? 4'd0 : p + 4'd1;
    endfunction

    // (a - b) mod 15 for a, b in 0..14; the 4-bit wrap of a+15-b lands in range.
    function automatic logic [3:0] ptr_sub(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? a - b : 4'(a + 4'd15 - b);
    endfunction

endpackage

// File: rtl/cic_comp_delay_line.sv
// Circular sample history: one write port with wrapping pointer, one read port indexed by
// tap age (0 = newest sample). Cleared together with the rest of the filter state.
module cic_comp_delay_line
    import cic_comp_pkg::*;
#(
    parameter int DATA_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic [3:0]                   rd_tap,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic [CIC_COMP_TAPS-1:0][DATA_WIDTH-1:0] mem;
    logic [3:0] wr_ptr;
    logic [3:0] newest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ptr_inc(wr_ptr);
        end
    end

    // No writes happen during MAC, so the slot behind wr_ptr is the sample being filtered.
    assign newest  = ptr_sub(wr_ptr, 4'd1);
    assign rd_data = mem[ptr_sub(newest, rd_tap)];

endmodule

// File: rtl/cic_comp_fir.sv
// Time-multiplexed 15-tap CIC compensation FIR: one MAC per clock, one result per strobe.
// Define CIC_COMP_SAT_EN to saturate the output; otherwise the output wraps.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int DATA_WIDTH   = 14,
    parameter int COEF_WIDTH   = 18,
    parameter int OUTPUT_WIDTH = 14,
    parameter int COEF_FRAC    = 17
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [DATA_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic                           busy,
    output logic                           overrun
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + 4;
    localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) << (COEF_FRAC - 1);

    cic_comp_state_e state, state_nxt;
    logic [3:0]                     tap;
    logic                           accept;
    logic signed [DATA_WIDTH-1:0]   x_rd;
    logic signed [COEF_WIDTH-1:0]   coef;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        rounded;
    logic signed [OUTPUT_WIDTH-1:0] result;

    cic_comp_delay_line #(.DATA_WIDTH(DATA_WIDTH)) u_dline (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept),
        .wr_data(in_data),
        .rd_tap (tap),
        .rd_data(x_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (in_valid) begin
                accept    = 1'b1;
                state_nxt = MAC;
            end
            MAC:  if (tap == 4'(CIC_COMP_TAPS - 1)) state_nxt = DONE;
            DONE: begin
                accept    = in_valid;
                state_nxt = in_valid ? MAC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign coef    = COEF_WIDTH'(CIC_COMP_COEFS[tap]);
    assign prod    = PROD_W'(x_rd) * PROD_W'(coef);
    assign rounded = acc + ROUND;

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (OUTPUT_WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [ACC_W-1:0] shifted;
    always_comb begin
        shifted = rounded >>> COEF_FRAC;
        if (shifted > SAT_MAX)      result = OUTPUT_WIDTH'(SAT_MAX);
        else if (shifted < SAT_MIN) result = OUTPUT_WIDTH'(SAT_MIN);
        else                        result = OUTPUT_WIDTH'(shifted);
    end
`else
    assign result = OUTPUT_WIDTH'(rounded >>> COEF_FRAC);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                acc <= '0;
                tap <= '0;
            end else if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                tap <= (tap == 4'(CIC_COMP_TAPS - 1)) ? 4'd0 : tap + 4'd1;
            end
            // A strobe mid-computation is dropped; the running sum is left untouched.
            if (state == MAC && in_valid) overrun <= 1'b1;
            if (state == DONE) begin
                out_data  <= result;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: a reference convolution predicts each output and its
// arrival cycle; a monitor pops and compares on every out_valid.
module tb_cic_comp_fir;
    import cic_comp_pkg::*;

    localparam int DW = 14;
    localparam int OW = 14;
`ifdef CIC_COMP_SAT_EN
    localparam longint SAT_EXP = 8191;
`else
    localparam longint SAT_EXP = -768;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_valid, busy, overrun;
    logic signed [DW-1:0] in_data;
    logic signed [OW-1:0] out_data;
    logic s_valid, s_out_valid, s_busy, s_overrun;
    logic signed [DW-1:0] s_data;
    logic signed [OW-1:0] s_out_data;

    always #5 clk = ~clk;

    cic_comp_fir dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .overrun(overrun)
    );

    cic_comp_fir #(.COEF_FRAC(15)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data),
        .out_valid(s_out_valid), .out_data(s_out_data), .busy(s_busy), .overrun(s_overrun)
    );

    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    int     hist [CIC_COMP_TAPS];
    longint exp_q[$];
    int     t_q[$];
    longint last_out = 0;
    longint s_last = 0;
    int     s_cnt = 0;
    logic   prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic longint model();
        longint a = 0;
        logic signed [OW-1:0] w;
        for (int k = 0; k < CIC_COMP_TAPS; k++) a += longint'(CIC_COMP_COEFS[k]) * hist[k];
        a = (a + (64'sd1 <<< 16)) >>> 17;
`ifdef CIC_COMP_SAT_EN
        if (a > 8191) a = 8191;
        if (a < -8192) a = -8192;
        return a;
`else
        w = a[OW-1:0];
        return longint'(w);
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output is registered on the 16th edge after the edge that samples the strobe.
    task automatic strobe(input int v, input bit acc_exp);
        in_valid = 1'b1;
        in_data  = DW'(v);
        if (acc_exp) begin
            for (int k = CIC_COMP_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = v;
            exp_q.push_back(model());
            t_q.push_back(cyc + 17);
        end
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic sstrobe(input int v);
        s_valid = 1'b1;
        s_data  = DW'(v);
        step(1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1);
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic flush_model();
        exp_q.delete();
        t_q.delete();
        for (int k = 0; k < CIC_COMP_TAPS; k++) hist[k] = 0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; s_valid = 1'b0; s_data = '0;
        flush_model();
        fork
            begin : mon
                longint e;
                int t;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (out_valid) begin
                            chk("ov_pulse", prev_ov, 0);
                            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                            else begin
                                e = exp_q.pop_front();
                                t = t_q.pop_front();
                                chk("out_data", out_data, e);
                                chk("out_time", cyc, t);
                            end
                            last_out = out_data;
                        end
                        if (s_out_valid) begin
                            s_last = s_out_data;
                            s_cnt++;
                        end
                    end
                    prev_ov = out_valid;
                end
            end
        join_none

        step(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        step(2);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);

        // Impulse; every strobe at 16-clock spacing lands on the DONE cycle.
        strobe(1000, 1);
        chk("busy_mac", busy, 1);
        step(15);
        repeat (16) begin strobe(0, 1); step(15); end
        drain();

        // DC level
        repeat (20) begin strobe(1000, 1); step(15); end
        drain();
        chk("dc_steady", last_out, 1000);
        chk("overrun_clear", overrun, 0);

        // Random samples with irregular gaps
        for (int i = 0; i < 12; i++) begin
            strobe(int'($urandom_range(12000)) - 6000, 1);
            step(15 + int'($urandom_range(4)));
        end
        drain();

        // Overrun: second strobe 8 clocks after the first is dropped
        strobe(500, 1);
        step(7);
        strobe(77, 0);
        chk("overrun_set", overrun, 1);
        chk("busy_during_overrun", busy, 1);
        drain();
        step(20);
        chk("overrun_sticky", overrun, 1);

        // Reset in the middle of a computation
        strobe(1234, 0);
        step(6);
        rst = 1'b1;
        flush_model();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        step(2);
        rst = 1'b0;
        chk("abort_overrun", overrun, 0);
        chk("abort_out_data", out_data, 0);
        step(25);
        strobe(8000, 1); step(15);
        strobe(-3000, 1); step(15);
        strobe(0, 1); step(15);
        drain();

        // Saturation / wrap with COEF_FRAC=15
        repeat (20) begin sstrobe(8000); step(15); end
        step(20);
        chk("sat_count", s_cnt, 20);
        chk("sat_steady", s_last, SAT_EXP);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
